// File: rtl/serial_pkg.sv
// Shared definitions for the serial link scheduler: FSM states, default
// frame timing and the round-robin winner search.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_GAP_CYC = 8;

   // First set bit of mask searching upward from last+1, wrapping modulo n (n <= 8).
   function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                          input logic [2:0] last,
                                          input int n);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = (int'(last) + k) % n;
         if (k <= n && !found && mask[3'(idx)]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester-side bus and serial pins of the scheduler; the master side
// drives requests, the slave side is the scheduler itself.
interface serial_tx_scheduler_if #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 8
);
   localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        grant;
   logic [OWN_W-1:0]        owner;
   logic                    busy;
   logic                    transmission;
   logic                    clock;
   logic                    data;

   modport master (
      output req, req_data,
      input  grant, owner, busy, transmission, clock, data
   );

   modport slave (
      input  req, req_data,
      output grant, owner, busy, transmission, clock, data
   );
endinterface

// File: rtl/serial_shifter.sv
// Serial clock divider and MSB-first shift register for one frame;
// done is asserted during the last cycle of the frame.
import serial_pkg::*;

module serial_shifter #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_byte,
   output logic              clock,
   output logic              data,
   output logic              done
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);

   logic              active;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              half_end;

   assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   assign done     = half_end && clock && (bit_cnt == BIT_W'(DATA_W - 1));
   assign data     = shreg[DATA_W-1];

   // The next bit is shifted up only on the falling serial edge, so data is steady while clock is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         clock   <= 1'b0;
      end else if (load) begin
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= load_byte;
         clock   <= 1'b0;
      end else if (half_end) begin
         div_cnt <= '0;
         if (!clock) begin
            clock <= 1'b1;
         end else begin
            clock <= 1'b0;
            if (done) begin
               active <= 1'b0;
               shreg  <= '0;
            end else begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               shreg   <= shreg << 1;
            end
         end
      end else if (active) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end
endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin owner of the shared serial link: arbitrates requesters,
// hands the winner's byte to the shifter and enforces the inter-frame gap.
import serial_pkg::*;

module serial_tx_scheduler #(
   parameter int N_REQ   = 3,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int GAP_CYC = DEF_GAP_CYC
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_tx_scheduler_if.slave bus
);
   localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   state_t            state;
   logic [OWN_W-1:0]  last;
   logic [OWN_W-1:0]  win;
   logic              load;
   logic              done;
   logic [DATA_W-1:0] load_byte;
   logic [GAP_W-1:0]  gap_cnt;

   always_comb begin
      win       = OWN_W'(rr_pick(8'(bus.req), 3'(last), N_REQ));
      load      = (state == IDLE) && (|bus.req);
      load_byte = bus.req_data[int'(win)*DATA_W +: DATA_W];
   end

   // last resets to the top index so requester 0 wins the first decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         last             <= OWN_W'(N_REQ - 1);
         gap_cnt          <= '0;
         bus.grant        <= '0;
         bus.owner        <= '0;
         bus.busy         <= 1'b0;
         bus.transmission <= 1'b0;
      end else begin
         bus.grant <= '0;
         case (state)
            IDLE: begin
               if (load) begin
                  bus.grant[win]   <= 1'b1;
                  bus.owner        <= win;
                  last             <= win;
                  bus.busy         <= 1'b1;
                  bus.transmission <= 1'b1;
                  state            <= SHIFT;
               end
            end
            SHIFT: begin
               if (done) begin
                  bus.transmission <= 1'b0;
                  gap_cnt          <= '0;
                  state            <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   serial_shifter #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_byte (load_byte),
      .clock     (bus.clock),
      .data      (bus.data),
      .done      (done)
   );
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: a time-since-grant reference model checks every
// cycle, a vector table covers arbitration/data, hand sequences cover corner cases.
module tb_serial_tx_scheduler;
   localparam int N_REQ   = 3;
   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int GAP_CYC = 4;
   localparam int FRAME   = DATA_W * 2 * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   model_on = 1'b0;

   serial_tx_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   serial_tx_scheduler #(
      .N_REQ   (N_REQ),
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s at cycle %0d: bound expired, got timeout, want event", name, cyc);
   endtask

   function automatic int rr_model(input logic [2:0] m, input int last);
      for (int k = 1; k <= N_REQ; k++)
         if (m[(last + k) % N_REQ]) return (last + k) % N_REQ;
      return -1;
   endfunction

   // Reference model: position in the frame is just cycles elapsed since the grant.
   bit         m_active = 1'b0;
   int         m_t = 0;
   logic [7:0] m_byte = '0;
   int         m_owner = 0;
   int         m_last = N_REQ - 1;
   logic [2:0] m_grant = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_active <= 1'b0;
         m_t      <= 0;
         m_owner  <= 0;
         m_last   <= N_REQ - 1;
         m_grant  <= '0;
         m_byte   <= '0;
      end else if (m_active) begin
         m_grant <= '0;
         m_t     <= m_t + 1;
         if (m_t + 1 == FRAME + GAP_CYC) m_active <= 1'b0;
      end else begin
         m_grant <= '0;
         if (bus.req != 0) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_byte   <= bus.req_data[rr_model(bus.req, m_last)*DATA_W +: DATA_W];
            m_owner  <= rr_model(bus.req, m_last);
            m_last   <= rr_model(bus.req, m_last);
            m_grant  <= 3'(1 << rr_model(bus.req, m_last));
         end
      end
   end

   always @(negedge clk) begin
      logic e_tx, e_clk, e_data;
      if (model_on) begin
         e_tx   = m_active && (m_t < FRAME);
         e_clk  = e_tx && ((m_t % (2*CLK_DIV)) >= CLK_DIV);
         e_data = e_tx ? m_byte[7 - m_t/(2*CLK_DIV)] : 1'b0;
         check("model_grant", 32'(bus.grant), 32'(m_grant));
         check("model_owner", 32'(bus.owner), 32'(m_owner));
         check("model_busy", 32'(bus.busy), 32'(m_active));
         check("model_transmission", 32'(bus.transmission), 32'(e_tx));
         check("model_clock", 32'(bus.clock), 32'(e_clk));
         check("model_data", 32'(bus.data), 32'(e_data));
      end
   end

   task automatic apply_stimulus(input logic [2:0] r, input logic [23:0] d);
      bus.req      = r;
      bus.req_data = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(3'b000, 24'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_grant(output logic [2:0] g, output int at);
      int waited = 0;
      while (bus.grant == 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (bus.grant == 0) fail_now("grant_wait");
      g  = bus.grant;
      at = cyc;
   endtask

   task automatic get_frame(output logic [7:0] b, output int len, output int nbits);
      logic prev = 1'b0;
      b = '0;
      len = 0;
      nbits = 0;
      while (bus.transmission && len < 100) begin
         if (bus.clock && !prev) begin
            b = {b[6:0], bus.data};
            nbits++;
         end
         prev = bus.clock;
         len++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int waited = 0;
      while (bus.busy && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (bus.busy) fail_now("idle_wait");
      @(negedge clk);
   endtask

   task automatic check_output(input string name, input logic [2:0] g_exp, input logic [7:0] b_exp);
      logic [2:0] g;
      logic [7:0] b;
      int at, len, nbits;
      wait_grant(g, at);
      check({name, "_grant"}, 32'(g), 32'(g_exp));
      bus.req = '0;
      get_frame(b, len, nbits);
      check({name, "_byte"}, 32'(b), 32'(b_exp));
      check({name, "_len"}, 32'(len), 32'(FRAME));
      check({name, "_nbits"}, 32'(nbits), 32'(DATA_W));
      wait_idle();
   endtask

   typedef struct {
      logic [2:0]  req;
      logic [23:0] data;
      logic [2:0]  exp_grant;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [2:0] g;
      logic [7:0] b;
      int at, prev_at, len, nbits, seen;
      int exp_order[4];

      vecs[0] = '{3'b001, 24'h0000A5, 3'b001, 8'hA5};
      vecs[1] = '{3'b110, 24'hC33C00, 3'b010, 8'h3C};
      vecs[2] = '{3'b100, 24'h810000, 3'b100, 8'h81};
      vecs[3] = '{3'b111, 24'h22117E, 3'b001, 8'h7E};
      vecs[4] = '{3'b101, 24'h99005A, 3'b001, 8'h5A};
      vecs[5] = '{3'b010, 24'h009600, 3'b010, 8'h96};

      apply_stimulus(3'b000, 24'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_on = 1'b1;
      check("reset_grant", 32'(bus.grant), 0);
      check("reset_owner", 32'(bus.owner), 0);
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_transmission", 32'(bus.transmission), 0);

      // Table: each vector starts from reset, so requester 0 holds priority.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         apply_stimulus(vecs[i].req, vecs[i].data);
         check_output($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_byte);
      end

      $display("[TB] all requesters held from reset");
      do_reset();
      apply_stimulus(3'b111, 24'h332211);
      exp_order = '{0, 1, 2, 0};
      prev_at = 0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, at);
         check("all_grant", 32'(g), 32'(1 << exp_order[i]));
         if (i > 0) check("all_spacing", 32'(at - prev_at), 32'(FRAME + GAP_CYC + 1));
         prev_at = at;
         @(negedge clk);
      end

      $display("[TB] fairness between requesters 1 and 2");
      do_reset();
      apply_stimulus(3'b110, 24'h5544FF);
      exp_order = '{1, 2, 1, 2};
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, at);
         check("fair_grant", 32'(g), 32'(1 << exp_order[i]));
         check("fair_owner", 32'(bus.owner), 32'(exp_order[i]));
         @(negedge clk);
      end

      $display("[TB] late request mid-frame");
      do_reset();
      apply_stimulus(3'b001, 24'h0000C6);
      wait_grant(g, prev_at);
      check("late_first_grant", 32'(g), 32'b001);
      bus.req = '0;
      fork
         begin
            repeat (10) @(negedge clk);
            apply_stimulus(3'b100, 24'h5F00C6);
         end
      join_none
      get_frame(b, len, nbits);
      check("late_inflight_byte", 32'(b), 32'hC6);
      check("late_inflight_len", 32'(len), 32'(FRAME));
      wait_grant(g, at);
      check("late_second_grant", 32'(g), 32'b100);
      check("late_second_delay", 32'(at - prev_at), 32'(FRAME + GAP_CYC + 1));
      bus.req = '0;
      wait_idle();

      $display("[TB] reset mid-frame");
      do_reset();
      apply_stimulus(3'b010, 24'h00E700);
      wait_grant(g, at);
      bus.req = '0;
      repeat (3*2*CLK_DIV + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_grant", 32'(bus.grant), 0);
      check("midrst_owner", 32'(bus.owner), 0);
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_transmission", 32'(bus.transmission), 0);
      check("midrst_clock", 32'(bus.clock), 0);
      check("midrst_data", 32'(bus.data), 0);
      apply_stimulus(3'b111, 24'h12345A);
      check_output("midrst_prio", 3'b001, 8'h5A);
      apply_stimulus(3'b010, 24'h006B00);
      check_output("midrst_req1", 3'b010, 8'h6B);

      $display("[TB] request withdrawn during gap");
      do_reset();
      apply_stimulus(3'b100, 24'h420000);
      wait_grant(g, at);
      check("withdraw_grant", 32'(g), 32'b100);
      get_frame(b, len, nbits);
      check("withdraw_byte", 32'(b), 32'h42);
      bus.req = '0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.grant != 0) seen++;
      end
      check("withdraw_no_grant", 32'(seen), 0);
      check("withdraw_busy", 32'(bus.busy), 0);
      check("withdraw_transmission", 32'(bus.transmission), 0);

      $display("[TB] randomized traffic");
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom);
         if ($urandom_range(0, 7) == 0) bus.req_data = 24'($urandom);
         rst = ($urandom_range(0, 299) == 0);
      end
      rst = 1'b0;
      bus.req = '0;
      repeat (50) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
